// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, debouncer, press/release edge pulses,
// hold detection and optional auto-repeat press pulses. Channels are fully independent.
module button_conditioner #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] btn_raw,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic [CHANNELS-1:0] btn_held
);

    localparam int unsigned DebWidth  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldWidth = $clog2(HOLD_CYCLES + REPEAT_CYCLES);

    localparam logic [DebWidth-1:0]  DebLast   = DebWidth'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldWidth-1:0] HoldStart = HoldWidth'(HOLD_CYCLES);
    localparam logic [HoldWidth-1:0] HoldMax   = HoldWidth'(HOLD_CYCLES + REPEAT_CYCLES - 1);
    localparam logic [CHANNELS-1:0]  IdleLevel = {CHANNELS{ACTIVE_LOW}};

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] pressed;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IdleLevel;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // 1 = pressed, independent of the pin polarity
    assign pressed = sync_q[SYNC_STAGES-1] ^ IdleLevel;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [DebWidth-1:0]  deb_cnt_q, deb_cnt_d;
        logic [HoldWidth-1:0] hold_cnt_q, hold_cnt_d;
        logic                 level_q, level_d;
        logic                 prev_q;

        always_comb begin
            deb_cnt_d = deb_cnt_q;
            level_d   = level_q;
            if (pressed[g] == level_q) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DebLast) begin
                level_d   = ~level_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DebWidth'(1);
            end
        end

        // Hold count equals the pressed-cycle index; after the first repeat window it cycles
        // HoldStart..HoldMax so it never wraps while the key stays down.
        always_comb begin
            hold_cnt_d = '0;
            if (level_d && level_q) begin
                if (hold_cnt_q == HoldMax) begin
                    hold_cnt_d = HoldStart;
                end else begin
                    hold_cnt_d = hold_cnt_q + HoldWidth'(1);
                end
            end
        end

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                prev_q     <= 1'b0;
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                prev_q     <= level_q;
            end
        end

        // A hold count of exactly HoldStart marks both the first held cycle and every repeat
        assign btn_level[g]   = level_q;
        assign btn_press[g]   = (level_q & ~prev_q) | (repeat_en[g] & (hold_cnt_q == HoldStart));
        assign btn_release[g] = ~level_q & prev_q;
        assign btn_held[g]    = (hold_cnt_q >= HoldStart);
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised front end for the board's push-buttons (Run, Continue, Reset-style keys) feeding the SLC3 control logic.
- Per channel: synchronises the raw active-low button, debounces it and produces a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Adds a new hold-detect output and optional auto-repeat press pulses, so one held Continue key can single-step repeatedly.
- Channels are fully independent; one instance serves all keys.

Parameters:
- CHANNELS, 2, number of independent button channels.
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (minimum 1).
- HOLD_CYCLES, 25000000, pressed cycles before btn_held asserts (minimum 1).
- REPEAT_CYCLES, 5000000, period of auto-repeat press pulses once held (minimum 1).
- ACTIVE_LOW, 1, 1 = raw input 0 means pressed; 0 = raw input 1 means pressed.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- btn_raw  in  CHANNELS  raw asynchronous button pins.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, sampled every cycle.
- btn_level  out  CHANNELS  debounced state, 1 = pressed.
- btn_press  out  CHANNELS  one-cycle pulse on accepted press and on each auto-repeat.
- btn_release  out  CHANNELS  one-cycle pulse on accepted release.
- btn_held  out  CHANNELS  1 while pressed for at least HOLD_CYCLES cycles.

Behaviour:
- Reset low (asynchronous), per channel:
  - Synchroniser flops load the idle level (1 if ACTIVE_LOW, else 0).
  - Debounce and hold counters clear to 0.
  - btn_level, btn_press, btn_release and btn_held are all 0.
- Normalisation: the last sync stage is XORed with ACTIVE_LOW, giving s = 1 when pressed.
- Debounce:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s equals btn_level, the counter clears.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while s still differs, btn_level toggles on the next edge and the counter clears.
  - Any single cycle with s equal to btn_level (a bounce) restarts the count.
- Latency: a clean raw edge appears on btn_level exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges later.
- btn_press is high for exactly the first cycle btn_level reads 1. btn_release is high for exactly the first cycle btn_level reads 0 after being 1.
- Hold counter:
  - Counts while btn_level = 1 and clears when btn_level = 0.
  - It is 0 in the first pressed cycle.
  - It saturates at HOLD_CYCLES + REPEAT_CYCLES - 1 and then reloads to HOLD_CYCLES on each repeat, so it never wraps.
- btn_held asserts in the pressed cycle where the hold counter reaches HOLD_CYCLES. It deasserts in the same cycle btn_level drops to 0.
- Auto-repeat, with repeat_en = 1 in the relevant cycle:
  - An extra btn_press pulse occurs in the cycle btn_held first asserts.
  - Further pulses follow every REPEAT_CYCLES cycles while still pressed.
  - Clearing repeat_en suppresses further repeat pulses immediately and does not affect btn_held.
- Edge cases:
  - btn_press and btn_release are never high together on one channel.
  - Simultaneous events on different channels are independent.
- Button held through reset release: the chain starts idle, so the press is accepted after the normal latency with one btn_press pulse.
- Reset asserted mid-debounce or mid-hold aborts the operation. No release pulse is generated.
- DEBOUNCE_CYCLES = 1: a change is accepted after 1 differing cycle.

Test Plan:
All tests use CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=1.
- Reset: hold Reset=0 with btn_raw=2'b00 -> all outputs 0. Release Reset -> btn_level[0] rises exactly 6 edges later with one btn_press[0] pulse.
- Clean press/release on ch0:
  - btn_raw[0]=0 at edge T -> btn_level[0]=1 and btn_press[0]=1 at T+6, btn_press[0]=0 at T+7.
  - btn_raw[0]=1 at edge R -> btn_release[0] is a one-cycle pulse at R+6.
- Bounce: btn_raw[0] toggles 0,1,0,1 every 2 cycles, then stays 0 -> no output change during bouncing. One btn_press follows 6 cycles after the final settle.
- Hold and repeat, with repeat_en[1]=1 and ch1 held 30 cycles after acceptance:
  - btn_held[1] rises at pressed cycle 10.
  - btn_press[1] pulses at pressed cycles 0, 10, 13, 16, 19, 22, 25, 28.
  - On release, btn_held[1] drops in the same cycle as btn_level[1].
- repeat_en=0: same hold on ch1 -> btn_held[1] asserts at pressed cycle 10, but btn_press[1] pulses only at pressed cycle 0.
- Reset mid-operation: pull Reset low 3 cycles into a ch0 debounce -> outputs 0 immediately, no btn_press. Channel 1 is simultaneously pressed and also clears.
